// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small prefetch queue.
//
// Issues one instruction-memory read at a time starting at RESET_PC and
// queues returned words together with their pc+4 for the IF/ID stage.
// A redirect flushes the queue and restarts fetching at the word-aligned
// target. A request that is in flight when a redirect arrives is allowed
// to complete, but its data is thrown away.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  prefetch queue depth, power of two in 2..16
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous reset, active low
//   stall_i        IF/ID cannot accept an instruction this cycle
//   redirect_i     taken branch/jump/jr
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_req_o     memory read request, held until acked
//   imem_addr_o    memory read address, held until acked
//   imem_ack_i     memory data valid for the outstanding request
//   imem_data_i    memory read data
//   instr_valid_o  instr_o / pc_4_o hold a valid instruction
//   instr_o        instruction at the head of the queue (0 when invalid)
//   pc_4_o         address of that instruction plus 4 (0 when invalid)
//
// Build option
//   FETCH_BYPASS_EN  when defined, an ack arriving with the queue empty,
//                    no stall and no redirect is forwarded to instr_o in
//                    the same cycle instead of being queued.
//
// state | meaning
// IDLE  | no request outstanding; issue when the queue has room
// BUSY  | request outstanding; its data is kept
// DROP  | request outstanding after a redirect; its data is discarded

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_4_o
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   pc4_mem_q   [FIFO_DEPTH];

  logic          fifo_empty;
  logic          fifo_full;
  logic          ack_accept;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [AW:0]   count_nxt;
  logic [31:0]   pc_plus4;
  logic [31:0]   redirect_tgt;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == DEPTH_C);
  assign pc_plus4     = fetch_pc_q + 32'd4;
  assign redirect_tgt = redirect_pc_i & ~32'h3;
  // Acks are only meaningful while a kept request is outstanding; acks in
  // IDLE (e.g. stale ones after reset) and in DROP never reach the queue.
  assign ack_accept   = (state_q == ST_BUSY) && imem_ack_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = ack_accept && fifo_empty && !stall_i && !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  assign push      = ack_accept && !redirect_i && !bypass;
  assign pop       = !fifo_empty && !stall_i && !redirect_i;
  assign count_nxt = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else if (redirect_i) begin
      // Redirect wins over everything: flush, retarget, and never push or
      // pop in the same cycle.
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fetch_pc_q <= redirect_tgt;
      case (state_q)
        ST_BUSY: begin
          if (imem_ack_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end else begin
            // Request and address must stay stable until acked.
            state_q <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_ack_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end else begin
      count_q <= count_nxt;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_full) begin
            state_q <= ST_BUSY;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end
        ST_BUSY: begin
          if (imem_ack_i) begin
            fetch_pc_q <= pc_plus4;
            // Chain straight into the next request only if the queue will
            // still have room after this cycle's push and pop.
            if (count_nxt != DEPTH_C) begin
              addr_q <= pc_plus4;
            end else begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (imem_ack_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Queue storage needs no reset; entries are only read when count_q says so.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data_i;
      pc4_mem_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = 32'h0;
    pc_4_o        = 32'h0;
    if (!fifo_empty) begin
      instr_valid_o = 1'b1;
      instr_o       = instr_mem_q[rd_ptr_q];
      pc_4_o        = pc4_mem_q[rd_ptr_q];
    end else if (bypass) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_data_i;
      pc_4_o        = pc_plus4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with default
// parameters (RESET_PC = 32'h0040_0000, FIFO_DEPTH = 4).
//
// Memory model: in auto mode a request visible in one cycle is acked in
// the following cycle with data = ~address. In manual mode the stimulus
// drives imem_ack_i / imem_data_i directly.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_4_o;

  int n_checks = 0;
  int n_errors = 0;

  logic mem_auto;
  logic mem_seen;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_4_o        (pc_4_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, land 1 time unit past the edge and update the
  // memory model from the freshly registered request outputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (imem_ack_i) begin
        imem_ack_i = 1'b0;
        mem_seen   = imem_req_o;
      end else if (imem_req_o) begin
        if (mem_seen) begin
          imem_ack_i  = 1'b1;
          imem_data_i = ~imem_addr_o;
        end else begin
          mem_seen = 1'b1;
        end
      end else begin
        mem_seen = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_ack_i    = 1'b0;
    imem_data_i   = 32'h0;
    mem_auto      = 1'b0;
    mem_seen      = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    int got_n;
    logic [31:0] exp_pc4;

    // ---- reset values ----
    do_reset();
    reset = 1'b0;
    step();
    chk("rst_req",   {31'h0, imem_req_o},    32'h0);
    chk("rst_addr",  imem_addr_o,            32'h0);
    chk("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("rst_instr", instr_o,                32'h0);
    chk("rst_pc4",   pc_4_o,                 32'h0);

    // ---- streaming fetch, 1-cycle memory ----
    do_reset();
    mem_auto = 1'b1;
    step();
    chk("first_req",  {31'h0, imem_req_o}, 32'h1);
    chk("first_addr", imem_addr_o,         32'h0040_0000);
    step();
    chk("ack_cycle_valid", {31'h0, instr_valid_o}, 32'h0);
    step();
    chk("w0_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("w0_pc4",   pc_4_o,                 32'h0040_0004);
    chk("w0_instr", instr_o,                ~32'h0040_0000);
    exp_pc4 = 32'h0040_0008;
    got_n   = 0;
    for (int i = 0; i < 20 && got_n < 2; i++) begin
      step();
      if (instr_valid_o) begin
        chk("stream_pc4",   pc_4_o,  exp_pc4);
        chk("stream_instr", instr_o, ~(exp_pc4 - 32'd4));
        exp_pc4 = exp_pc4 + 32'd4;
        got_n++;
      end
    end
    chk("stream_count", got_n, 2);

    // ---- stall fills the queue, release drains it in order ----
    do_reset();
    mem_auto = 1'b1;
    stall_i  = 1'b1;
    repeat (30) step();
    chk("full_req",   {31'h0, imem_req_o},    32'h0);
    chk("full_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("full_head",  pc_4_o,                 32'h0040_0004);
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'h0, instr_valid_o}, 32'h1);
      chk("drain_pc4",   pc_4_o,  32'h0040_0004 + 32'(4 * i));
      chk("drain_instr", instr_o, ~(32'h0040_0000 + 32'(4 * i)));
      step();
    end

    // ---- redirect while BUSY without ack -> DROP ----
    do_reset();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0103;
    step();
    redirect_i = 1'b0;
    chk("drop_req",  {31'h0, imem_req_o}, 32'h1);
    chk("drop_addr", imem_addr_o,         32'h0040_0000);
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hDEAD_BEEF;
    step();
    imem_ack_i = 1'b0;
    chk("drop_done_req",   {31'h0, imem_req_o},    32'h0);
    chk("drop_done_valid", {31'h0, instr_valid_o}, 32'h0);
    step();
    chk("drop_next_req",   {31'h0, imem_req_o},    32'h1);
    chk("drop_next_addr",  imem_addr_o,            32'h0040_0100);
    chk("drop_next_valid", {31'h0, instr_valid_o}, 32'h0);

    // ---- redirect with coincident ack and pending pop ----
    do_reset();
    step();
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h1111_0000;
    step();
    chk("co_pre_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("co_pre_addr",  imem_addr_o,            32'h0040_0004);
    imem_data_i   = 32'h2222_0000;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0050_0000;
    step();
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
    chk("co_valid", {31'h0, instr_valid_o}, 32'h0);
    chk("co_instr", instr_o,                32'h0);
    chk("co_pc4",   pc_4_o,                 32'h0);
    chk("co_req",   {31'h0, imem_req_o},    32'h0);
    step();
    chk("co_next_req",  {31'h0, imem_req_o}, 32'h1);
    chk("co_next_addr", imem_addr_o,         32'h0050_0000);

    // ---- pc wrap at top of address space ----
    do_reset();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap_idle_req", {31'h0, imem_req_o}, 32'h0);
    step();
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h1234_5678;
    step();
    imem_ack_i = 1'b0;
    chk("wrap_valid",     {31'h0, instr_valid_o}, 32'h1);
    chk("wrap_pc4",       pc_4_o,                 32'h0);
    chk("wrap_instr",     instr_o,                32'h1234_5678);
    chk("wrap_next_req",  {31'h0, imem_req_o},    32'h1);
    chk("wrap_next_addr", imem_addr_o,            32'h0);

    // ---- reset mid-request, then spurious ack ----
    do_reset();
    step();
    chk("mid_req", {31'h0, imem_req_o}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req",  {31'h0, imem_req_o}, 32'h0);
    chk("mid_rst_addr", imem_addr_o,         32'h0);
    reset       = 1'b1;
    imem_ack_i  = 1'b1;
    imem_data_i = 32'hBAD0_BAD0;
    step();
    imem_ack_i = 1'b0;
    chk("spur_req",   {31'h0, imem_req_o},    32'h1);
    chk("spur_addr",  imem_addr_o,            32'h0040_0000);
    chk("spur_valid", {31'h0, instr_valid_o}, 32'h0);
    step();
    chk("spur_valid2", {31'h0, instr_valid_o}, 32'h0);
    imem_ack_i  = 1'b1;
    imem_data_i = 32'h0000_600D;
    step();
    imem_ack_i = 1'b0;
    chk("spur_good_valid", {31'h0, instr_valid_o}, 32'h1);
    chk("spur_good_pc4",   pc_4_o,                 32'h0040_0004);
    chk("spur_good_instr", instr_o,                32'h0000_600D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
